// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS store-trace checker: checker states and default widths.
package mips_tb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Scratch address the MIPS test programs write to without it being part of the trace
    localparam logic [ADDR_W_DEF-1:0] IGN_ADDR_DEF = ADDR_W_DEF'(80);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

endpackage

// File: rtl/exp_table.sv
// Expected-store register file: appends at the write pointer, presents the entry at the read pointer.
module exp_table
    import mips_tb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_adv,
    output logic [ADDR_W-1:0] rd_addr_c,
    output logic [DATA_W-1:0] rd_data_c,
    output logic [IDX_W-1:0]  rd_ptr,
    output logic [CNT_W-1:0]  count,
    output logic              full_c
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              wr_ok;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign wr_ok     = wr_en && !full_c && !clr;
    assign rd_addr_c = addr_mem[rd_ptr];
    assign rd_data_c = data_mem[rd_ptr];

    // Storage carries no reset; a zero count makes stale entries unreachable
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            addr_mem[count[IDX_W-1:0]] <= wr_addr;
            data_mem[count[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count  <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) count <= count + CNT_W'(1);
            if (rd_adv) rd_ptr <= rd_ptr + IDX_W'(1);
        end
    end

endmodule

// File: rtl/store_trace_checker.sv
// Monitors core store traffic against a loaded table of expected (address, data) stores, in order.
module store_trace_checker
    import mips_tb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_wr,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              ign_en,
    input  logic [ADDR_W-1:0] ign_addr,
    input  logic              start,
    input  logic              clear,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              load_ovf,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W:0]    match_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              ign_en_q;
    logic [ADDR_W-1:0] ign_addr_q;
    logic              clr;
    logic              wr_en, rd_adv, capture, latch_ign, ovf_set;
    logic              ign_hit_c, hit_c;
    logic [ADDR_W-1:0] tab_addr_c;
    logic [DATA_W-1:0] tab_data_c;
    logic [IDX_W-1:0]  rd_ptr;
    logic [IDX_W:0]    tab_count;
    logic              tab_full_c;

    assign clr       = reset || clear;
    assign ign_hit_c = ign_en_q && (dataadr == ign_addr_q);
    assign hit_c     = (dataadr == tab_addr_c) && (writedata == tab_data_c);

    exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tab (
        .clk       (clk),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_addr   (exp_addr),
        .wr_data   (exp_data),
        .rd_adv    (rd_adv),
        .rd_addr_c (tab_addr_c),
        .rd_data_c (tab_data_c),
        .rd_ptr    (rd_ptr),
        .count     (tab_count),
        .full_c    (tab_full_c)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        wr_en     = 1'b0;
        rd_adv    = 1'b0;
        capture   = 1'b0;
        latch_ign = 1'b0;
        ovf_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_en   = exp_wr && !tab_full_c;
                ovf_set = exp_wr && tab_full_c;
                if (start) begin
                    latch_ign = 1'b1;
                    cyc_d     = '0;
                    // An entry written alongside start belongs to this run
                    state_d   = (tab_count == '0 && !wr_en) ? ST_PASS : ST_RUN;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (memwrite && !ign_hit_c) begin
                    if (hit_c) begin
                        rd_adv = 1'b1;
                        if (match_cnt + (IDX_W+1)'(1) == tab_count) state_d = ST_PASS;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
                // A store deciding the run on the last cycle wins over the timeout
                if (state_d == ST_RUN && cyc_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = ST_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cyc_q     <= '0;
            match_cnt <= '0;
            load_ovf  <= 1'b0;
            fail_idx  <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            if (rd_adv)  match_cnt <= match_cnt + (IDX_W+1)'(1);
            if (ovf_set) load_ovf  <= 1'b1;
            if (capture) begin
                fail_idx  <= rd_ptr;
                fail_addr <= dataadr;
                fail_data <= writedata;
            end
            busy    <= (state_d == ST_RUN);
            done    <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
            pass    <= (state_d == ST_PASS);
            fail    <= (state_d == ST_FAIL);
            timeout <= (state_d == ST_TIMEOUT);
        end
    end

    // Ignore settings survive clear; only reset drops them
    always_ff @(posedge clk) begin
        if (reset) begin
            ign_en_q   <= 1'b0;
            ign_addr_q <= '0;
        end else if (latch_ign && !clear) begin
            ign_en_q   <= ign_en;
            ign_addr_q <= ign_addr;
        end
    end

endmodule
